// File: rtl/motor_pkg.sv
// Shared definitions for the motor ramp controller:
// motor block register map, control bits, FSM states.
package motor_pkg;

    localparam logic [2:0] REG_OVF  = 3'd0;
    localparam logic [2:0] REG_CTRL = 3'd2;
    localparam logic [2:0] REG_CMP  = 3'd3;
    localparam logic [2:0] REG_DIR  = 3'd7;

    localparam logic [31:0] CTRL_TIMER_EN = 32'h0000_0001;
    localparam logic [31:0] CTRL_PWM_EN   = 32'h0000_0010;

    typedef enum logic [3:0] {
        ST_INIT_OVF,
        ST_INIT_CTRL,
        ST_INIT_CMP,
        ST_INIT_DIR,
        ST_RUN,
        ST_WR_CMP,
        ST_WR_DIR,
        ST_WAIT_DEAD,
        ST_ESTOP
    } state_t;

    // Word address of a motor register: [4:2] select, rest zero.
    function automatic logic [7:0] reg_addr(input logic [2:0] r);
        reg_addr = {3'b000, r, 2'b00};
    endfunction

    // One ramp step from cur toward tgt, limited to step, never past tgt.
    function automatic logic [15:0] ramp_step(
        input logic [15:0] cur,
        input logic [15:0] tgt,
        input logic [15:0] step
    );
        logic [15:0] d;
        if (tgt >= cur) begin
            d = tgt - cur;
            ramp_step = (d > step) ? cur + step : tgt;
        end else begin
            d = cur - tgt;
            ramp_step = (d > step) ? cur - step : tgt;
        end
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Enable-gated divider: one-cycle tick every N enabled cycles.
// Synchronous clear restarts the phase.
module tick_divider #(
    parameter logic [19:0] N = 20'd5000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    logic [19:0] r_cnt;

    assign o_tick = i_en && !i_clr && (r_cnt == N - 20'd1);

    // Count enabled cycles, wrapping on the tick.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? 20'd0 : r_cnt + 20'd1;
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Motor block bus master: init sequence, soft duty ramps,
// dead-timed direction reversal and emergency stop.
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter logic [15:0] PERIOD     = 16'd1000,
    parameter logic [15:0] STEP       = 16'd10,
    parameter logic [19:0] STEP_TICKS = 20'd5000,
    parameter logic [19:0] DEAD_TICKS = 20'd2000
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_duty,
    input  logic [3:0]  cmd_dir,
    input  logic        estop,
    output logic        bus_write_en,
    output logic [7:0]  bus_addr,
    output logic [31:0] bus_write_data,
    output logic [15:0] cur_duty,
    output logic [3:0]  cur_dir,
    output logic        at_target
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_tgt_duty;
    logic [3:0]  r_tgt_dir;
    logic [15:0] r_cur_duty;
    logic [3:0]  r_cur_dir;
    logic [15:0] r_new_duty;
    logic        r_we;
    logic [7:0]  r_addr;
    logic [31:0] r_data;

    logic        w_we;
    logic [2:0]  w_reg;
    logic [31:0] w_data;
    logic        w_duty_upd;
    logic [15:0] w_duty_val;
    logic        w_dir_upd;
    logic        w_latch;
    logic        w_live;
    logic        w_estop_hit;
    logic        w_hs;
    logic        w_dir_pend;
    logic [15:0] w_eff;
    logic [15:0] w_step;
    logic [15:0] w_clamped;
    logic        w_ramp_tick;
    logic        w_dead_tick;

    assign w_live = (r_state == ST_RUN) || (r_state == ST_WR_CMP) ||
                    (r_state == ST_WR_DIR) || (r_state == ST_WAIT_DEAD);
    assign w_estop_hit = w_live && estop;

    assign cmd_ready = ((r_state == ST_RUN) ||
                        (r_state == ST_WAIT_DEAD)) && !estop;
    assign w_hs      = cmd_valid && cmd_ready;
    assign w_clamped = (cmd_duty > PERIOD) ? PERIOD : cmd_duty;

    // A pending reversal ramps to zero before anything else.
    assign w_dir_pend = (r_tgt_dir != r_cur_dir);
    assign w_eff      = w_dir_pend ? 16'd0 : r_tgt_duty;
    assign w_step     = ramp_step(r_cur_duty, w_eff, STEP);

    tick_divider #(.N(STEP_TICKS)) u_ramp_div (
        .i_clk   (pclk),
        .i_reset (reset),
        .i_clr   (w_estop_hit || (r_state == ST_ESTOP)),
        .i_en    (w_live),
        .o_tick  (w_ramp_tick)
    );

    tick_divider #(.N(DEAD_TICKS)) u_dead_div (
        .i_clk   (pclk),
        .i_reset (reset),
        .i_clr   (w_estop_hit || (r_state != ST_WAIT_DEAD)),
        .i_en    (r_state == ST_WAIT_DEAD),
        .o_tick  (w_dead_tick)
    );

    // Next state and the bus write issued from the current state.
    always_comb begin
        w_next     = r_state;
        w_we       = 1'b0;
        w_reg      = REG_OVF;
        w_data     = 32'd0;
        w_duty_upd = 1'b0;
        w_duty_val = r_cur_duty;
        w_dir_upd  = 1'b0;
        w_latch    = 1'b0;
        if (w_estop_hit) begin
            w_we       = 1'b1;
            w_reg      = REG_CMP;
            w_data     = {16'd0, PERIOD};
            w_duty_upd = 1'b1;
            w_duty_val = 16'd0;
            w_next     = ST_ESTOP;
        end else begin
            unique case (r_state)
                ST_INIT_OVF: begin
                    w_we   = 1'b1;
                    w_reg  = REG_OVF;
                    w_data = {16'd0, PERIOD};
                    w_next = ST_INIT_CTRL;
                end
                ST_INIT_CTRL: begin
                    w_we   = 1'b1;
                    w_reg  = REG_CTRL;
                    w_data = CTRL_TIMER_EN | CTRL_PWM_EN;
                    w_next = ST_INIT_CMP;
                end
                ST_INIT_CMP: begin
                    w_we   = 1'b1;
                    w_reg  = REG_CMP;
                    w_data = {16'd0, PERIOD};
                    w_next = ST_INIT_DIR;
                end
                ST_INIT_DIR: begin
                    w_we   = 1'b1;
                    w_reg  = REG_DIR;
                    w_data = 32'd0;
                    w_next = ST_RUN;
                end
                ST_RUN: begin
                    if (w_dir_pend && (r_cur_duty == 16'd0)) begin
                        w_next = ST_WAIT_DEAD;
                    end else if (w_ramp_tick &&
                                 (w_step != r_cur_duty)) begin
                        w_latch = 1'b1;
                        w_next  = ST_WR_CMP;
                    end
                end
                ST_WR_CMP: begin
                    w_we       = 1'b1;
                    w_reg      = REG_CMP;
                    w_data     = {16'd0, PERIOD - r_new_duty};
                    w_duty_upd = 1'b1;
                    w_duty_val = r_new_duty;
                    w_next     = ST_RUN;
                end
                ST_WR_DIR: begin
                    w_we      = 1'b1;
                    w_reg     = REG_DIR;
                    w_data    = {28'd0, r_tgt_dir};
                    w_dir_upd = 1'b1;
                    w_next    = ST_RUN;
                end
                ST_WAIT_DEAD: begin
                    if (!w_dir_pend) begin
                        w_next = ST_RUN;
                    end else if (w_dead_tick) begin
                        w_next = ST_WR_DIR;
                    end
                end
                ST_ESTOP: begin
                    if (!estop) begin
                        w_next = ST_RUN;
                    end
                end
                default: begin
                    w_next = ST_INIT_OVF;
                end
            endcase
        end
    end

    // State, registered bus outputs, and target/current tracking.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state    <= ST_INIT_OVF;
            r_tgt_duty <= '0;
            r_tgt_dir  <= '0;
            r_cur_duty <= '0;
            r_cur_dir  <= '0;
            r_new_duty <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_state <= w_next;
            r_we    <= w_we;
            r_addr  <= w_we ? reg_addr(w_reg) : 8'd0;
            r_data  <= w_we ? w_data : 32'd0;
            if (w_duty_upd) begin
                r_cur_duty <= w_duty_val;
            end
            if (w_dir_upd) begin
                r_cur_dir <= r_tgt_dir;
            end
            if (w_latch) begin
                r_new_duty <= w_step;
            end
            if (w_estop_hit) begin
                r_tgt_duty <= 16'd0;
            end else if (w_hs) begin
                r_tgt_duty <= w_clamped;
                r_tgt_dir  <= cmd_dir;
            end
        end
    end

    assign bus_write_en   = r_we;
    assign bus_addr       = r_addr;
    assign bus_write_data = r_data;
    assign cur_duty       = r_cur_duty;
    assign cur_dir        = r_cur_dir;
    assign at_target      = (r_state == ST_RUN) &&
                            (r_cur_duty == r_tgt_duty) &&
                            (r_cur_dir == r_tgt_dir);

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Scoreboard bench for motor_ramp_ctrl with shortened
// tick periods so the full-range ramp fits the cycle budget.
module tb_motor_ramp_ctrl;

    localparam logic [15:0] PERIOD     = 16'd1000;
    localparam logic [15:0] STEP       = 16'd10;
    localparam logic [19:0] STEP_TICKS = 20'd100;
    localparam logic [19:0] DEAD_TICKS = 20'd40;
    localparam int ST = 100;
    localparam int DT = 40;

    localparam int K_NONE = 0;
    localparam int K_PREV = 1;
    localparam int K_MARK = 2;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          kind;
        int          lo;
        int          hi;
    } exp_t;

    typedef struct {
        logic [127:0] name;
        logic [31:0]  act;
        logic [31:0]  exp;
    } chk_t;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_duty = '0;
    logic [3:0]  cmd_dir = '0;
    logic        estop = 1'b0;
    logic        bus_write_en;
    logic [7:0]  bus_addr;
    logic [31:0] bus_write_data;
    logic [15:0] cur_duty;
    logic [3:0]  cur_dir;
    logic        at_target;

    exp_t q[$];
    chk_t cq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   mark_cyc = 0;
    int   prev_wr = 0;

    motor_ramp_ctrl #(
        .PERIOD     (PERIOD),
        .STEP       (STEP),
        .STEP_TICKS (STEP_TICKS),
        .DEAD_TICKS (DEAD_TICKS)
    ) dut (
        .pclk           (pclk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_duty       (cmd_duty),
        .cmd_dir        (cmd_dir),
        .estop          (estop),
        .bus_write_en   (bus_write_en),
        .bus_addr       (bus_addr),
        .bus_write_data (bus_write_data),
        .cur_duty       (cur_duty),
        .cur_dir        (cur_dir),
        .at_target      (at_target)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every bus write and
    // evaluates queued level checks from the stimulus.
    always @(negedge pclk) begin
        exp_t e;
        chk_t c;
        int   ref_cyc;
        if (bus_write_en) begin
            n_checks++;
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write addr %h data %0d",
                         bus_addr, bus_write_data);
            end else begin
                e = q.pop_front();
                if (bus_addr !== e.addr ||
                    bus_write_data !== e.data) begin
                    n_errors++;
                    $display("FAIL write got %h/%0d expected %h/%0d",
                             bus_addr, bus_write_data, e.addr, e.data);
                end
                if (e.kind != K_NONE) begin
                    ref_cyc = (e.kind == K_PREV) ? prev_wr : mark_cyc;
                    n_checks++;
                    if ((cyc - ref_cyc) < e.lo ||
                        (cyc - ref_cyc) > e.hi) begin
                        n_errors++;
                        $display("FAIL write_gap addr %h got %0d expected %0d..%0d",
                                 bus_addr, cyc - ref_cyc, e.lo, e.hi);
                    end
                end
            end
            prev_wr = cyc;
        end
        while (cq.size() > 0) begin
            c = cq.pop_front();
            n_checks++;
            if (c.act !== c.exp) begin
                n_errors++;
                $display("FAIL %0s got %0d expected %0d",
                         c.name, c.act, c.exp);
            end
        end
    end

    task automatic chk(input logic [127:0] name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        cq.push_back(c);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d,
                           input int kind, input int lo, input int hi);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.kind = kind;
        e.lo   = lo;
        e.hi   = hi;
        q.push_back(e);
    endtask

    task automatic push_cmp(input int duty, input int kind);
        push_wr(8'h0C, 32'(int'(PERIOD) - duty), kind, ST, ST);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic send_cmd(input logic [15:0] d, input logic [3:0] dr);
        logic ok;
        ok = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_duty  = d;
        cmd_dir   = dr;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_duty(input logic [15:0] v, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge pclk);
            if (cur_duty == v) ok = 1'b1;
        end
        chk("wait_duty", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge pclk);
            if (q.size() == 0) ok = 1'b1;
        end
        chk("sb_drain", {31'd0, ok}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge pclk);
        reset = 1'b1;
        cycles(3);
        chk("rst_we", {31'd0, bus_write_en}, 32'd0);
        chk("rst_duty", {16'd0, cur_duty}, 32'd0);
        chk("rst_dir", {28'd0, cur_dir}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_at_tgt", {31'd0, at_target}, 32'd0);
        push_wr(8'h00, 32'd1000, K_MARK, 1, 1);
        push_wr(8'h08, 32'h11, K_PREV, 1, 1);
        push_wr(8'h0C, 32'd1000, K_PREV, 1, 1);
        push_wr(8'h1C, 32'd0, K_PREV, 1, 1);
        reset = 1'b0;
        mark_cyc = cyc;
        wait_idle(20);
        cycles(2);
        chk("init_at_tgt", {31'd0, at_target}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        cycles(2);
        do_reset();

        // Ramp up to 35 from 0.
        push_cmp(10, K_NONE);
        push_cmp(20, K_PREV);
        push_cmp(30, K_PREV);
        push_cmp(35, K_PREV);
        send_cmd(16'd35, 4'd0);
        wait_duty(16'd35, 6 * ST);
        wait_idle(10);
        cycles(2);
        chk("t2_at_tgt", {31'd0, at_target}, 32'd1);

        // Down to 30, then reverse to dir 1 at duty 20.
        push_cmp(30, K_NONE);
        send_cmd(16'd30, 4'd0);
        wait_duty(16'd30, 3 * ST);
        push_cmp(20, K_NONE);
        push_cmp(10, K_PREV);
        push_cmp(0, K_PREV);
        push_wr(8'h1C, 32'd1, K_PREV, DT, DT + 4);
        push_cmp(10, K_NONE);
        push_cmp(20, K_PREV);
        send_cmd(16'd20, 4'd1);
        wait_duty(16'd20, 3 * ST);
        wait_duty(16'd0, 4 * ST);
        wait_duty(16'd20, 5 * ST + DT);
        wait_idle(10);
        cycles(2);
        chk("t3_dir", {28'd0, cur_dir}, 32'd1);
        chk("t3_at_tgt", {31'd0, at_target}, 32'd1);

        // Reverse, then restore dir 1 inside the dead time.
        push_cmp(10, K_NONE);
        push_cmp(0, K_PREV);
        send_cmd(16'd20, 4'd0);
        wait_duty(16'd0, 4 * ST);
        cycles(5);
        chk("t6_ready_dead", {31'd0, cmd_ready}, 32'd1);
        push_cmp(10, K_NONE);
        push_cmp(20, K_PREV);
        send_cmd(16'd20, 4'd1);
        cycles(2 * DT);
        chk("t6_dir_kept", {28'd0, cur_dir}, 32'd1);
        wait_duty(16'd20, 4 * ST);
        wait_idle(10);
        cycles(2);
        chk("t6_at_tgt", {31'd0, at_target}, 32'd1);

        // Clamped ramp interrupted by estop at duty 500.
        for (int d = 30; d <= 500; d += 10) begin
            push_cmp(d, (d == 30) ? K_NONE : K_PREV);
        end
        send_cmd(16'd5000, 4'd1);
        wait_duty(16'd500, 60 * ST);
        wait_idle(10);
        cycles(3);
        push_wr(8'h0C, 32'd1000, K_MARK, 1, 1);
        estop = 1'b1;
        mark_cyc = cyc;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            chk("estop_ready", {31'd0, cmd_ready}, 32'd0);
        end
        chk("estop_duty", {16'd0, cur_duty}, 32'd0);
        estop = 1'b0;
        cycles(3 * ST);
        chk("estop_sb_empty", q.size(), 32'd0);
        chk("estop_at_tgt", {31'd0, at_target}, 32'd1);

        // Full-range clamped ramp: last compare is 0.
        for (int d = 10; d <= 1000; d += 10) begin
            push_cmp(d, (d == 10) ? K_NONE : K_PREV);
        end
        send_cmd(16'd5000, 4'd1);
        wait_duty(16'd1000, 110 * ST);
        cycles(3 * ST);
        chk("clamp_duty", {16'd0, cur_duty}, 32'd1000);
        chk("clamp_sb_empty", q.size(), 32'd0);
        chk("clamp_at_tgt", {31'd0, at_target}, 32'd1);

        // Reset mid-operation re-runs the init sequence.
        do_reset();
        chk("rerst_duty", {16'd0, cur_duty}, 32'd0);
        cycles(2 * ST);
        chk("final_sb_empty", q.size(), 32'd0);
        cycles(3);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
